// File: rtl/pc_branch_sequencer.sv
// rtl/pc_branch_sequencer.sv - fetch PC sequencer with taken-branch redirect and flush bubbles
// Optional macro BRANCH_STATS_EN adds saturating branch / taken-branch counters.
module pc_branch_sequencer #(
    parameter int         N            = 19,
    parameter logic [N:0] RESET_PC     = '0,
    parameter int         FLUSH_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       stall,
    input  logic       br_valid,
    input  logic       jump_select,
    input  logic [N:0] br_target,
    output logic [N:0] pc,
    output logic       fetch_valid,
    output logic       flush,
    output logic       in_flush
`ifdef BRANCH_STATS_EN
    ,
    output logic [15:0] br_count,
    output logic [15:0] taken_count
`endif
);

    typedef enum logic [1:0] {
        ST_START = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    // Bubble counter is loaded with FLUSH_CYCLES-1 so that the FLUSH state
    // lasts exactly FLUSH_CYCLES cycles (count down to zero, then leave).
    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

    state_t     state_q, state_d;
    logic [N:0] pc_q, pc_d;
    logic       fetch_valid_q, fetch_valid_d;
    logic       flush_q, flush_d;
    logic [3:0] cnt_q, cnt_d;
    logic       taken;

    // br_valid gates jump_select so an unknown comparator result cannot reach pc
    assign taken = br_valid & jump_select;

    // State register and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_START;
            pc_q          <= RESET_PC;
            fetch_valid_q <= 1'b0;
            flush_q       <= 1'b0;
            cnt_q         <= 4'd0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            fetch_valid_q <= fetch_valid_d;
            flush_q       <= flush_d;
            cnt_q         <= cnt_d;
        end
    end

    // Next-state and next-PC selection: taken branch beats stall beats increment
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        fetch_valid_d = fetch_valid_q;
        flush_d       = 1'b0;
        cnt_d         = cnt_q;
        case (state_q)
            ST_START: begin
                state_d       = ST_RUN;
                fetch_valid_d = 1'b1;
            end
            ST_RUN: begin
                if (taken) begin
                    pc_d          = br_target;
                    flush_d       = 1'b1;
                    fetch_valid_d = 1'b0;
                    state_d       = ST_FLUSH;
                    cnt_d         = FLUSH_LOAD;
                end else if (!stall) begin
                    pc_d = pc_q + (N+1)'(1);
                end
            end
            ST_FLUSH: begin
                // wrong-path branches and stall are ignored while draining
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d       = ST_RUN;
                    fetch_valid_d = 1'b1;
                end
            end
            default: begin
                state_d       = ST_START;
                fetch_valid_d = 1'b0;
                cnt_d         = 4'd0;
            end
        endcase
    end

    assign pc          = pc_q;
    assign fetch_valid = fetch_valid_q;
    assign flush       = flush_q;
    assign in_flush    = (state_q == ST_FLUSH);

`ifdef BRANCH_STATS_EN
    logic [15:0] br_count_q, br_count_d;
    logic [15:0] taken_count_q, taken_count_d;

    // Statistics registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_count_q    <= 16'd0;
            taken_count_q <= 16'd0;
        end else begin
            br_count_q    <= br_count_d;
            taken_count_q <= taken_count_d;
        end
    end

    // Count only branches resolved on the correct path (RUN); saturate at all-ones
    always_comb begin
        br_count_d    = br_count_q;
        taken_count_d = taken_count_q;
        if ((state_q == ST_RUN) && br_valid) begin
            if (br_count_q != 16'hFFFF) begin
                br_count_d = br_count_q + 16'd1;
            end
            if (jump_select && (taken_count_q != 16'hFFFF)) begin
                taken_count_d = taken_count_q + 16'd1;
            end
        end
    end

    assign br_count    = br_count_q;
    assign taken_count = taken_count_q;
`endif

endmodule

// File: tb/tb_pc_branch_sequencer.sv
// tb/tb_pc_branch_sequencer.sv - scoreboard bench for pc_branch_sequencer
module tb_pc_branch_sequencer;

    localparam int         N  = 19;
    localparam int         FC = 2;
    localparam logic [N:0] RPC = 20'h00000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       stall = 1'b0;
    logic       br_valid = 1'b0;
    logic       jump_select = 1'b0;
    logic [N:0] br_target = '0;
    logic [N:0] pc;
    logic       fetch_valid;
    logic       flush;
    logic       in_flush;
`ifdef BRANCH_STATS_EN
    logic [15:0] br_count;
    logic [15:0] taken_count;
`endif

    always #5 clk = ~clk;

    pc_branch_sequencer #(
        .N(N),
        .RESET_PC(RPC),
        .FLUSH_CYCLES(FC)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .stall(stall),
        .br_valid(br_valid),
        .jump_select(jump_select),
        .br_target(br_target),
        .pc(pc),
        .fetch_valid(fetch_valid),
        .flush(flush),
        .in_flush(in_flush)
`ifdef BRANCH_STATS_EN
        ,
        .br_count(br_count),
        .taken_count(taken_count)
`endif
    );

    typedef struct {
        logic [N:0]  pc;
        logic        fv;
        logic        fl;
        logic        inf;
        logic [15:0] bc;
        logic [15:0] tc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // reference model state: "fetch is live once started and no bubbles remain"
    bit          m_started = 0;
    int          m_bubbles = 0;
    int unsigned m_pc = 0;
    bit          m_fv = 0, m_fl = 0, m_inf = 0;
    int          m_bc = 0, m_tc = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, expv);
        end
    endtask

    // Apply one cycle of inputs, predict the outputs after the next rising edge.
    task automatic step(input logic r, input logic s, input logic bv, input logic js,
                        input logic [N:0] t);
        logic prev_r;
        exp_t e;
        @(negedge clk);
        prev_r      = rst_n;
        rst_n       = r;
        stall       = s;
        br_valid    = bv;
        jump_select = js;
        br_target   = t;
        if (prev_r && !r) begin
            #1;
            chk("async_rst_pc", 32'(pc), 32'(RPC));
            chk("async_rst_fv", 32'(fetch_valid), 0);
            chk("async_rst_flush", 32'(flush), 0);
            chk("async_rst_inflush", 32'(in_flush), 0);
        end
        if (!r) begin
            m_started = 0; m_bubbles = 0; m_pc = 32'(RPC);
            m_fv = 0; m_fl = 0; m_inf = 0; m_bc = 0; m_tc = 0;
        end else if (!m_started) begin
            m_started = 1; m_fv = 1; m_fl = 0; m_inf = 0;
        end else if (m_bubbles > 0) begin
            m_bubbles--;
            m_fl  = 0;
            m_fv  = (m_bubbles == 0);
            m_inf = (m_bubbles != 0);
        end else begin
            if (bv) begin
                if (m_bc < 65535) m_bc++;
                if (js === 1'b1 && m_tc < 65535) m_tc++;
            end
            if (bv && js === 1'b1) begin
                m_pc = 32'(t); m_bubbles = FC; m_fl = 1; m_fv = 0; m_inf = 1;
            end else begin
                m_fl = 0;
                if (!s) m_pc = (m_pc + 1) % (1 << (N+1));
            end
        end
        e.pc = m_pc[N:0]; e.fv = m_fv; e.fl = m_fl; e.inf = m_inf;
        e.bc = 16'(m_bc); e.tc = 16'(m_tc);
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, 0, '0);
    endtask

    // Monitor: compare DUT outputs against the oldest prediction after every edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("pc", 32'(pc), 32'(e.pc));
                chk("fetch_valid", 32'(fetch_valid), 32'(e.fv));
                chk("flush", 32'(flush), 32'(e.fl));
                chk("in_flush", 32'(in_flush), 32'(e.inf));
`ifdef BRANCH_STATS_EN
                chk("br_count", 32'(br_count), 32'(e.bc));
                chk("taken_count", 32'(taken_count), 32'(e.tc));
`endif
            end
        end
    end

    initial begin
        #1;
        chk("reset_pc", 32'(pc), 32'(RPC));
        chk("reset_fv", 32'(fetch_valid), 0);
        chk("reset_flush", 32'(flush), 0);
        chk("reset_inflush", 32'(in_flush), 0);

        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, '0);
        idle(6);                                   // pc 0..5
        for (int i = 0; i < 3; i++) step(1, 1, 0, 0, '0);   // hold at 5
        idle(5);                                   // 6..10
        step(1, 0, 1, 1, 20'h00400);               // taken at pc=10
        idle(4);
        step(1, 0, 1, 1, 20'h00014);               // redirect to 20
        step(1, 0, 1, 1, 20'h0ABCD);               // wrong-path, ignored
        step(1, 1, 0, 0, '0);                      // stall ignored in flush
        step(1, 0, 1, 0, 20'h0DEAD);               // not-taken at pc=20
        idle(2);
        step(1, 1, 1, 1, 20'h00777);               // taken overrides stall
        idle(4);
        step(1, 0, 1, 1, 20'hFFFFE);
        idle(6);                                   // wraps through 0
        step(1, 0, 1, 1, 20'h12345);
        step(0, 0, 0, 0, '0);                      // reset during flush cycle 1
        step(0, 0, 0, 0, '0);
        idle(3);
        step(1, 0, 0, 1'bx, 20'h3FFFF);            // unqualified jump_select
        idle(2);

        for (int i = 0; i < 3000; i++) begin
            logic r, s, bv, js;
            r  = ($urandom_range(0, 199) != 0);
            s  = ($urandom_range(0, 3) == 0);
            bv = ($urandom_range(0, 9) < 3);
            js = $urandom_range(0, 1) != 0;
            step(r, s, bv, js, (N+1)'($urandom));
        end
        idle(1);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        #2;
        chk("scoreboard_drained", 32'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_branch_sequencer.md
Name: pc_branch_sequencer

Overview:
- Program-counter sequencer that consumes the branch comparator's jump_select.
- Holds the fetch PC, advances it sequentially, and redirects it to the branch target on a taken branch.
- On a redirect it squashes the wrong-path fetch slots for a fixed number of bubble cycles.
- Sits between the execute stage (comparator, target adder) and instruction fetch.

Parameters:
- N, 19, MSB index of PC and target; both are N+1 bits wide, matching the comparator datapath width.
- RESET_PC, 0, PC value loaded on reset.
- FLUSH_CYCLES, 2, number of fetch bubbles after a taken branch; legal range 1..15.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- stall  input  1  fetch hold request from downstream.
- br_valid  input  1  a branch is resolving in execute this cycle; jump_select is meaningful only when high.
- jump_select  input  1  branch taken, from the branch comparator.
- br_target  input  N+1  branch destination address.
- pc  output  N+1  current fetch address, registered.
- fetch_valid  output  1  pc is a valid fetch this cycle, registered.
- flush  output  1  one-cycle pulse telling IF/ID to squash wrong-path instructions, registered.
- in_flush  output  1  high while in FLUSH state.

Behaviour:
- One clock; reset is asynchronous and active-low (rst_n); all state is in the clk domain.
- Reset values: pc=RESET_PC, fetch_valid=0, flush=0, in_flush=0, state=START, bubble count=0.
- States: START, RUN, FLUSH.
- START: exactly one cycle after rst_n deasserts.
  - Next state RUN; fetch_valid becomes 1; pc unchanged, so the first fetch is at RESET_PC.
  - br_valid is ignored.
- RUN: fetch_valid=1. Priority per cycle, highest first:
  - (a) Taken branch (br_valid & jump_select):
    - Next cycle: pc=br_target, flush=1, fetch_valid=0, state=FLUSH, count=FLUSH_CYCLES-1.
    - A taken branch overrides stall.
  - (b) stall: pc held; a not-taken branch under stall also holds pc.
  - (c) Otherwise: pc=pc+1, modulo 2^(N+1); all-ones wraps to 0.
- FLUSH: fetch_valid=0, in_flush=1, pc held at target.
  - flush is high only in the first FLUSH cycle.
  - br_valid/jump_select are ignored (wrong-path).
  - stall does not pause the count.
  - If count!=0, decrement; if count==0, next state RUN with fetch_valid=1 and pc still = target.
- Timing: a taken branch sampled at edge T gives fetch_valid low for exactly FLUSH_CYCLES cycles. Fetch at target resumes at T+FLUSH_CYCLES+1.
- Branch latency: jump_select is sampled the same cycle it is presented; redirect is visible one cycle later.
- Reset mid-FLUSH or mid-RUN: immediate return to reset values; no partial redirect survives.
- br_valid=0: jump_select and br_target are don't-care.
- X on jump_select while br_valid=0 must not propagate to pc.

Optional Feature:
- Macro: BRANCH_STATS_EN.
- With the macro:
  - Adds outputs br_count[15:0] and taken_count[15:0], registered and reset to 0.
  - br_count increments on every br_valid sampled in RUN.
  - taken_count increments when jump_select is also high.
  - Both saturate at 16'hFFFF; FLUSH-state branches are not counted.
- Without the macro: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset release: rst_n low then high, RESET_PC=0, stall=0 → cycle 1 pc=0 fetch_valid=1; next cycles pc=1,2,3.
- Sequential with stall: pc=5, stall high for 3 cycles → pc stays 5 for 3 cycles, then 6.
- Taken branch, FLUSH_CYCLES=2: at pc=10, br_valid=1, jump_select=1, br_target=0x00400 → next cycle pc=0x00400, flush=1, fetch_valid=0; fetch_valid=0 for 2 cycles; third cycle fetch_valid=1, pc=0x00400; then 0x00401.
- Not-taken and ignored branches:
  - pc=20, br_valid=1, jump_select=0 → pc=21, no flush.
  - br_valid=1, jump_select=1 during FLUSH → no second redirect, bubble length unchanged.
  - Taken branch with stall=1 → redirect still occurs.
- Wrap and reset mid-flush:
  - pc=20'hFFFFF, no stall → pc=0.
  - Assert rst_n low during FLUSH cycle 1 → pc=RESET_PC, fetch_valid=0, flush=0 immediately.
- BRANCH_STATS_EN: 3 branches in RUN, 2 taken, plus 1 during FLUSH → br_count=3, taken_count=2. Preload near saturation → holds at 16'hFFFF.
